// File: rtl/qarma_round_engine.sv
// Iterative QARMAv2-64 round engine: N_ROUNDS forward or inverse rounds on one block,
// ROUNDS_PER_CYCLE rounds per clock, round constants read from an external ROM port.
module qarma_round_engine #(
  parameter int N_ROUNDS         = 7,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int IDXW             = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_inv,
  input  logic [63:0]                   in_data,
  input  logic [63:0]                   in_tk,
  output logic [IDXW-1:0]               rc_idx,
  input  logic [64*ROUNDS_PER_CYCLE-1:0] rc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_data,
  output logic                          busy
);

  localparam int RPC = ROUNDS_PER_CYCLE;
  localparam int C   = N_ROUNDS / RPC;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;
  // Cell i of the shuffle output takes cell TAU[i] of the input; cell 0 is the top nibble.
  localparam logic [63:0] TAU = 64'h0B6DA1C75E38F492;

  if (N_ROUNDS < 1 || (N_ROUNDS % RPC) != 0 || (1 << IDXW) < N_ROUNDS) begin : g_bad_params
    $error("qarma_round_engine: illegal N_ROUNDS/ROUNDS_PER_CYCLE/IDXW combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h4;  4'h1: sbox = 4'h7;  4'h2: sbox = 4'h9;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'hC;  4'h5: sbox = 4'h6;  4'h6: sbox = 4'hE;  4'h7: sbox = 4'hF;
      4'h8: sbox = 4'h0;  4'h9: sbox = 4'h5;  4'hA: sbox = 4'h1;  4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h8;  4'hD: sbox = 4'h3;  4'hE: sbox = 4'h2;  4'hF: sbox = 4'hA;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h8;  4'h1: inv_sbox = 4'hA;  4'h2: inv_sbox = 4'hE;  4'h3: inv_sbox = 4'hD;
      4'h4: inv_sbox = 4'h0;  4'h5: inv_sbox = 4'h9;  4'h6: inv_sbox = 4'h5;  4'h7: inv_sbox = 4'h1;
      4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h2;  4'hA: inv_sbox = 4'hF;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h4;  4'hD: inv_sbox = 4'hB;  4'hE: inv_sbox = 4'h6;  4'hF: inv_sbox = 4'h7;
      default: inv_sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] sub_cells(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 16; i++) begin
      if (inv) begin
        y[63-4*i -: 4] = inv_sbox(x[63-4*i -: 4]);
      end else begin
        y[63-4*i -: 4] = sbox(x[63-4*i -: 4]);
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] shuffle_cells(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int          t;
    y = 64'd0;
    for (int i = 0; i < 16; i++) begin
      t = int'(TAU[63-4*i -: 4]);
      if (inv) begin
        y[63-4*t -: 4] = x[63-4*i -: 4];
      end else begin
        y[63-4*i -: 4] = x[63-4*t -: 4];
      end
    end
    return y;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v, input int s);
    logic [7:0] w;
    w = {v, v} << s;
    return w[7:4];
  endfunction

  // circ(0, rho, rho^2, rho) over each column; the matrix is its own inverse.
  function automatic logic [63:0] mix_columns(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  acc;
    int          d;
    y = 64'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 4'h0;
        for (int j = 0; j < 4; j++) begin
          d = (j - r) & 3;
          if (d == 2) begin
            acc = acc ^ rotl(x[63-4*(4*j+c) -: 4], 2);
          end else if (d != 0) begin
            acc = acc ^ rotl(x[63-4*(4*j+c) -: 4], 1);
          end else begin
            acc = acc;
          end
        end
        y[63-4*(4*r+c) -: 4] = acc;
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] fwd_round(input logic [63:0] x, input logic [63:0] k);
    return sub_cells(mix_columns(shuffle_cells(x ^ k, 1'b0)), 1'b0);
  endfunction

  function automatic logic [63:0] inv_round(input logic [63:0] x, input logic [63:0] k);
    return shuffle_cells(mix_columns(sub_cells(x, 1'b1)), 1'b1) ^ k;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     data_q, data_d;
  logic [63:0]     tk_q, tk_d;
  logic            inv_q, inv_d;
  logic [63:0]     res_q, res_d;
  logic [63:0]     round_s;

  // K unrolled rounds; inverse walks the lanes from the highest constant down.
  always_comb begin
    round_s = data_q;
    if (inv_q) begin
      for (int j = RPC - 1; j >= 0; j--) begin
        round_s = inv_round(round_s, tk_q ^ rc_data[64*j +: 64]);
      end
    end else begin
      for (int j = 0; j < RPC; j++) begin
        round_s = fwd_round(round_s, tk_q ^ rc_data[64*j +: 64]);
      end
    end
  end

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    tk_d     = tk_q;
    inv_d    = inv_q;
    res_d    = res_q;
    in_ready = 1'b0;
    rc_idx   = {IDXW{1'b0}};
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          tk_d    = in_tk;
          inv_d   = in_inv;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (inv_q) begin
          rc_idx = IDXW'(N_ROUNDS - RPC) - IDXW'(cnt_q) * IDXW'(RPC);
        end else begin
          rc_idx = IDXW'(cnt_q) * IDXW'(RPC);
        end
        data_d = round_s;
        if (cnt_q == CW'(C - 1)) begin
          res_d   = round_s;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          data_d  = in_data;
          tk_d    = in_tk;
          inv_d   = in_inv;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      data_q  <= 64'd0;
      tk_q    <= 64'd0;
      inv_q   <= 1'b0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tk_q    <= tk_d;
      inv_q   <= inv_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_qarma_round_engine.sv
// Directed bench for qarma_round_engine: K=1 and K=7 instances against a bench-side
// nibble-array round model and a local constant ROM.
module tb_qarma_round_engine;

  localparam logic [63:0] ROM [8] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89, 64'h452821E638D01377, 64'hBE5466CF34E90C6C,
    64'hC0AC29B7C97C50DD, 64'h0000000000000000
  };
  localparam int TAU [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic          a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b0;
  logic [63:0]   a_in_data = 64'd0, a_in_tk = 64'd0;
  logic          a_in_ready, a_out_valid, a_busy;
  logic [2:0]    a_rc_idx;
  logic [63:0]   a_rc_data, a_out_data;

  logic          b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b0;
  logic [63:0]   b_in_data = 64'd0, b_in_tk = 64'd0;
  logic          b_in_ready, b_out_valid, b_busy;
  logic [2:0]    b_rc_idx;
  logic [447:0]  b_rc_data;
  logic [63:0]   b_out_data;

  always #5 clk = ~clk;

  assign a_rc_data = ROM[a_rc_idx];
  always_comb begin
    b_rc_data = '0;
    for (int j = 0; j < 7; j++) b_rc_data[64*j +: 64] = ROM[3'(b_rc_idx + 3'(j))];
  end

  qarma_round_engine #(.N_ROUNDS(7), .ROUNDS_PER_CYCLE(1), .IDXW(3)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .in_tk(a_in_tk), .rc_idx(a_rc_idx), .rc_data(a_rc_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  qarma_round_engine #(.N_ROUNDS(7), .ROUNDS_PER_CYCLE(7), .IDXW(3)) u_k7 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .in_tk(b_in_tk), .rc_idx(b_rc_idx), .rc_data(b_rc_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_sb(input logic [3:0] v);
    case (v)
      4'h0: return 4'h4;  4'h1: return 4'h7;  4'h2: return 4'h9;  4'h3: return 4'hB;
      4'h4: return 4'hC;  4'h5: return 4'h6;  4'h6: return 4'hE;  4'h7: return 4'hF;
      4'h8: return 4'h0;  4'h9: return 4'h5;  4'hA: return 4'h1;  4'hB: return 4'hD;
      4'hC: return 4'h8;  4'hD: return 4'h3;  4'hE: return 4'h2;  default: return 4'hA;
    endcase
  endfunction

  function automatic logic [3:0] m_rl(input logic [3:0] v, input int s);
    logic [7:0] w;
    w = {v, v} << s;
    return w[7:4];
  endfunction

  function automatic logic [63:0] m_round(input logic [63:0] x, input logic [63:0] k);
    logic [3:0]  n [16];
    logic [3:0]  p [16];
    logic [3:0]  m [16];
    logic [63:0] y;
    y = x ^ k;
    for (int i = 0; i < 16; i++) n[i] = y[63-4*i -: 4];
    for (int i = 0; i < 16; i++) p[i] = n[TAU[i]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[4*r+c] = m_rl(p[4*((r+1)%4)+c], 1) ^ m_rl(p[4*((r+2)%4)+c], 2) ^ m_rl(p[4*((r+3)%4)+c], 1);
    for (int i = 0; i < 16; i++) y[63-4*i -: 4] = m_sb(m[i]);
    return y;
  endfunction

  function automatic logic [63:0] m_fwd(input logic [63:0] x, input logic [63:0] tk);
    logic [63:0] s;
    s = x;
    for (int i = 0; i < 7; i++) s = m_round(s, tk ^ ROM[i]);
    return s;
  endfunction

  // Accept on K=1 engine, check the rc_idx walk and 7-cycle latency, then drain.
  task automatic run_a(input logic inv, input logic [63:0] d, input logic [63:0] tk,
                       input logic [63:0] exp, input bit scramble);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_inv = inv; a_in_data = d; a_in_tk = tk; a_out_ready = 1'b0;
    #1 check_eq("a_accept_ready", 64'(a_in_ready), 64'd1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (scramble) begin
        a_in_valid = 1'b1; a_in_inv = ~inv;
        a_in_data = {$urandom, $urandom}; a_in_tk = {$urandom, $urandom};
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      check_eq("a_rc_idx", 64'(a_rc_idx), inv ? 64'(6 - c) : 64'(c));
      check_eq("a_run_valid", 64'(a_out_valid), 64'd0);
      check_eq("a_run_ready", 64'(a_in_ready), 64'd0);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    check_eq("a_done_valid", 64'(a_out_valid), 64'd1);
    check_eq("a_result", a_out_data, exp);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    #1 check_eq("a_idle_busy", 64'(a_busy), 64'd0);
  endtask

  // Accept on K=7 engine; result is due one cycle after accept.
  task automatic run_b(input logic inv, input logic [63:0] d, input logic [63:0] tk,
                       input logic [63:0] exp);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_inv = inv; b_in_data = d; b_in_tk = tk; b_out_ready = 1'b0;
    #1 check_eq("b_accept_ready", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    b_in_inv = ~inv; b_in_data = ~d; b_in_tk = ~tk;
    #1;
    check_eq("b_rc_idx", 64'(b_rc_idx), 64'd0);
    check_eq("b_run_valid", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check_eq("b_done_valid", 64'(b_out_valid), 64'd1);
    check_eq("b_result", b_out_data, exp);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  logic [63:0] pt, tk0, ct, da, ta, ea, db, tb, eb;

  initial begin
    pt  = 64'h0123456789ABCDEF;
    tk0 = 64'hFEDCBA9876543210;
    ct  = m_fwd(pt, tk0);

    #1;
    check_eq("rst_a_ready", 64'(a_in_ready), 64'd1);
    check_eq("rst_a_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_a_busy", 64'(a_busy), 64'd0);
    check_eq("rst_a_data", a_out_data, 64'd0);
    check_eq("rst_a_rc_idx", 64'(a_rc_idx), 64'd0);
    check_eq("rst_b_valid", 64'(b_out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_a(1'b0, pt, tk0, ct, 1'b1);
    run_a(1'b1, ct, tk0, pt, 1'b1);
    run_b(1'b0, pt, tk0, ct);
    run_b(1'b1, ct, tk0, pt);

    // Backpressure, then back-to-back accept straight out of DONE.
    da = 64'hDEADBEEFCAFEF00D; ta = 64'h0F1E2D3C4B5A6978; ea = m_fwd(da, ta);
    db = 64'h0000000000000000; tb = 64'hFFFFFFFFFFFFFFFF; eb = m_fwd(db, tb);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = da; a_in_tk = ta;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    @(negedge clk);
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = db; a_in_tk = tb; a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("bp_valid", 64'(a_out_valid), 64'd1);
      check_eq("bp_data", a_out_data, ea);
      check_eq("bp_ready", 64'(a_in_ready), 64'd0);
      check_eq("bp_busy", 64'(a_busy), 64'd1);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    #1 check_eq("b2b_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    #1;
    check_eq("b2b_valid", 64'(a_out_valid), 64'd0);
    check_eq("b2b_busy", 64'(a_busy), 64'd1);
    check_eq("b2b_rc0", 64'(a_rc_idx), 64'd0);
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      #1 check_eq("b2b_rc_idx", 64'(a_rc_idx), 64'(c));
    end
    @(negedge clk);
    #1;
    check_eq("b2b_done", 64'(a_out_valid), 64'd1);
    check_eq("b2b_result", a_out_data, eb);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;

    // Asynchronous reset while cnt = 3.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = da; a_in_tk = ta;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    #1 check_eq("mid_rc_idx", 64'(a_rc_idx), 64'd3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(a_in_ready), 64'd1);
    check_eq("mid_rst_data", a_out_data, 64'd0);
    check_eq("mid_rst_busy", 64'(a_busy), 64'd0);
    check_eq("mid_rst_rc_idx", 64'(a_rc_idx), 64'd0);
    #2 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 check_eq("aborted_quiet", 64'(a_out_valid), 64'd0);
    end
    run_a(1'b0, db, tb, eb, 1'b1);
    run_a(1'b1, eb, tb, db, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
